row_loader: RTL and testbench
=============================

ROW_LOADER -- requirements
Module: row_loader

Interface
REQ-001 Parameter ROWS, default 8: matrix rows; row indices 0..ROWS-1.
REQ-002 Parameter COLS, default 8: pixel bytes per row.
REQ-003 Parameter SYNC, default 8'hA5: packet start byte.
REQ-004 clk  input  1  single clock; every register in the block is clocked on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data  input  8  received byte from the upstream UART receiver; valid only when data_ready=1.
REQ-007 data_ready  input  1  one-cycle strobe: data holds a new byte.
REQ-008 wr_en  output  1  framebuffer write strobe.
REQ-009 wr_addr  output  $clog2(ROWS*COLS)  framebuffer address, row*COLS+col.
REQ-010 wr_data  output  8  framebuffer write data.
REQ-011 frame_done  output  1  one-cycle pulse: row ROWS-1 has been committed.
REQ-012 err  output  1  one-cycle pulse: packet rejected (bad row index or checksum).
REQ-013 overrun  output  1  one-cycle pulse: a byte arrived during COMMIT and was dropped.
REQ-014 busy  output  1  high in every state except HUNT.

Function
REQ-015 Packet format: SYNC, ROW, COLS pixel bytes P0..P(COLS-1), CHK; CHK = ROW XOR P0 XOR ... XOR P(COLS-1).
REQ-016 States: HUNT, ROW, PIX, CHK, COMMIT; the FSM advances only on data_ready, except in COMMIT.
REQ-017 HUNT: a byte equal to SYNC -> ROW; any other byte is discarded, no pulse.
REQ-018 ROW: byte < ROWS -> store row index, initialise checksum to the byte, clear column counter, -> PIX; byte >= ROWS -> err pulse, -> HUNT.
REQ-019 PIX: byte written to local buffer[col], checksum ^= byte, col increments; after byte COLS-1 -> CHK.
REQ-020 Inside a packet SYNC has no special meaning and is treated as ordinary data.
REQ-021 CHK: byte == checksum -> COMMIT, col cleared; mismatch -> err pulse, -> HUNT; framebuffer untouched.
REQ-022 COMMIT: one write per cycle for COLS cycles: wr_en=1, wr_addr=row*COLS+col, wr_data=buffer[col]; col 0 first.
REQ-023 wr_en, wr_addr and wr_data are registered: the first write appears the cycle after the CHK byte's data_ready.
REQ-024 After the final COMMIT write the FSM returns to HUNT; if row == ROWS-1, frame_done pulses in the same cycle as that final write.
REQ-025 data_ready during COMMIT: byte dropped, overrun pulses the next cycle, COMMIT continues undisturbed.
REQ-026 wr_en, frame_done, err and overrun are single-cycle pulses; wr_addr and wr_data hold their last value while wr_en=0.
REQ-027 Checksum and counters use modular arithmetic; the column counter is $clog2(COLS+1) bits wide and never wraps mid-packet.
REQ-028 Rows may arrive in any order and be rewritten; frame_done depends only on row ROWS-1 being committed.

Reset
REQ-029 reset asserted -> immediately, regardless of clk: state=HUNT, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, err=0, overrun=0, busy=0.
REQ-030 On reset, checksum, row and column registers clear to 0; buffer contents are don't-care.
REQ-031 Reset mid-packet or mid-COMMIT abandons the packet; writes already issued stand, no further writes occur.
REQ-032 The first data_ready after reset deasserts is processed in HUNT.

Verification
REQ-033 ROWS=8, COLS=8: A5, 03, 01..08, CHK=03^01^..^08=0B -> 8 writes, addresses 24..31, data 01..08 on consecutive cycles; no err or frame_done.
REQ-034 A5, 07, eight bytes 00, CHK=07 -> writes to addresses 56..63 with data 00; frame_done pulses with the address-63 write.
REQ-035 A5, 03, 01..08, CHK=0C -> err pulse one cycle after CHK; wr_en never asserts; next A5 is accepted.
REQ-036 A5, 09 -> err pulse, FSM in HUNT; following bytes 11, A5, 00, 8 pixels, valid CHK -> row 0 written.
REQ-037 data_ready injected two cycles into COMMIT -> overrun pulse; all 8 writes still complete with correct data.
REQ-038 reset asserted between PIX bytes 4 and 5 -> outputs 0 asynchronously; a later complete packet for row 2 writes only addresses 16..23.

Source files
------------

// File: rtl/row_loader.sv
// row_loader
//
// Receives framed row packets from a byte stream (typically a UART receiver)
// and commits each validated row into an external framebuffer.
//
// Packet: SYNC, ROW, P0 .. P(COLS-1), CHK  with  CHK = ROW ^ P0 ^ ... ^ P(COLS-1)
//
// Pixels are staged in a local row buffer. The framebuffer is written only
// after the checksum matches, so a corrupted packet never disturbs it.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   data        received byte, meaningful only while data_ready=1
//   data_ready  one-cycle strobe marking a new byte on data
//   wr_en       framebuffer write strobe (one write per cycle while committing)
//   wr_addr     framebuffer address row*COLS+col; holds its value while wr_en=0
//   wr_data     framebuffer write data; holds its value while wr_en=0
//   frame_done  pulse together with the last write of row ROWS-1
//   err         pulse when a packet is rejected (row out of range or bad checksum)
//   overrun     pulse when a byte arrived during a commit and was dropped
//   busy        high whenever the loader is not hunting for SYNC
module row_loader #(
  parameter int         ROWS = 8,
  parameter int         COLS = 8,
  parameter logic [7:0] SYNC = 8'hA5,
  localparam int        AW   = $clog2(ROWS * COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    data,
  input  logic          data_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          frame_done,
  output logic          err,
  output logic          overrun,
  output logic          busy
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS + 1);
  localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_HUNT,
    S_ROW,
    S_PIX,
    S_CHK,
    S_COMMIT
  } state_t;

  state_t        state;
  logic [RW-1:0] row_idx;
  logic [7:0]    csum;
  logic [CW-1:0] col;
  logic [7:0]    buffer [COLS];
  logic [IW-1:0] col_idx;

  assign col_idx = col[IW-1:0];
  assign busy    = (state != S_HUNT);

  function automatic logic [AW-1:0] fb_addr(input logic [RW-1:0] r, input logic [IW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  // ---- stage: pixel staging buffer (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (state == S_PIX && data_ready)
      buffer[col_idx] <= data;
  end

  // ---- stage: packet parser and framebuffer commit ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_HUNT;
      row_idx    <= '0;
      csum       <= '0;
      col        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      overrun    <= 1'b0;

      case (state)
        S_HUNT: begin
          if (data_ready && data == SYNC)
            state <= S_ROW;
        end

        S_ROW: begin
          if (data_ready) begin
            if (int'(data) < ROWS) begin
              row_idx <= data[RW-1:0];
              csum    <= data;
              col     <= '0;
              state   <= S_PIX;
            end else begin
              err   <= 1'b1;
              state <= S_HUNT;
            end
          end
        end

        S_PIX: begin
          if (data_ready) begin
            csum <= csum ^ data;
            col  <= col + CW'(1);
            if (col == LAST_COL)
              state <= S_CHK;
          end
        end

        S_CHK: begin
          if (data_ready) begin
            if (data == csum) begin
              // Column 0 is issued on the accepting edge so the first write
              // lands the cycle after the CHK byte; col then points at column 1.
              wr_en   <= 1'b1;
              wr_addr <= fb_addr(row_idx, {IW{1'b0}});
              wr_data <= buffer[{IW{1'b0}}];
              col     <= CW'(1);
              if (LAST_COL == '0) begin
                frame_done <= (row_idx == LAST_ROW);
                state      <= S_HUNT;
              end else begin
                state <= S_COMMIT;
              end
            end else begin
              err   <= 1'b1;
              state <= S_HUNT;
            end
          end
        end

        S_COMMIT: begin
          // Incoming bytes are dropped here; the commit is never stalled.
          overrun <= data_ready;
          wr_en   <= 1'b1;
          wr_addr <= fb_addr(row_idx, col_idx);
          wr_data <= buffer[col_idx];
          col     <= col + CW'(1);
          if (col == LAST_COL) begin
            frame_done <= (row_idx == LAST_ROW);
            state      <= S_HUNT;
          end
        end

        default: state <= S_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_row_loader.sv
// Bench for row_loader: directed packets with literal expectations plus a
// randomized byte stream checked every cycle against a packet-level model.
module tb_row_loader;

  localparam int         ROWS = 8;
  localparam int         COLS = 8;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         AW   = $clog2(ROWS * COLS);
  localparam int         MAXC = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          data_ready = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_done;
  logic          err;
  logic          overrun;
  logic          busy;

  row_loader #(.ROWS(ROWS), .COLS(COLS), .SYNC(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .data_ready (data_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .err        (err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int total = 0;
  int bad   = 0;

  // Expected outputs indexed by the rising edge that produces them.
  bit            exp_we   [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  logic [7:0]    exp_data [MAXC];
  bit            exp_fd   [MAXC];
  bit            exp_err  [MAXC];
  bit            exp_ovr  [MAXC];
  bit            exp_busy [MAXC];

  // Packet-level model state.
  bit         in_pkt = 1'b0;
  logic [7:0] pq[$];
  int         commit_end = -1;

  // Observation logs for directed checks.
  int obs_addr[$];
  int obs_data[$];
  int obs_edge[$];
  int err_e[$];
  int fd_e[$];
  int ovr_e[$];

  logic [7:0] pix [COLS];
  int last_edge = 0;
  int chk_edge  = 0;

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic clear_logs();
    obs_addr.delete(); obs_data.delete(); obs_edge.delete();
    err_e.delete(); fd_e.delete(); ovr_e.delete();
  endtask

  // Apply one received byte (or idle) at rising edge e to the model.
  task automatic model_edge(input int e, input bit v, input logic [7:0] b);
    logic [7:0] x;
    if (e + COLS >= MAXC) return;
    if (v) begin
      if (e <= commit_end) begin
        exp_ovr[e] = 1'b1;
      end else if (!in_pkt) begin
        if (b == SYNC) begin
          in_pkt = 1'b1;
          pq.delete();
        end
      end else begin
        pq.push_back(b);
        if (pq.size() == 1) begin
          if (int'(b) >= ROWS) begin
            exp_err[e] = 1'b1;
            in_pkt = 1'b0;
          end
        end else if (pq.size() == COLS + 2) begin
          x = 8'h00;
          for (int i = 0; i < COLS + 1; i++) x ^= pq[i];
          if (x == pq[COLS + 1]) begin
            for (int j = 0; j < COLS; j++) begin
              exp_we[e + j]   = 1'b1;
              exp_addr[e + j] = AW'(int'(pq[0]) * COLS + j);
              exp_data[e + j] = pq[1 + j];
            end
            if (int'(pq[0]) == ROWS - 1) exp_fd[e + COLS - 1] = 1'b1;
            commit_end = e + COLS - 1;
          end else begin
            exp_err[e] = 1'b1;
          end
          in_pkt = 1'b0;
        end
      end
    end
    exp_busy[e] = in_pkt || (e < commit_end);
  endtask

  task automatic model_reset();
    in_pkt = 1'b0;
    pq.delete();
    commit_end = -1;
    for (int i = cyc + 1; i < MAXC; i++) begin
      exp_we[i] = 1'b0; exp_fd[i] = 1'b0; exp_err[i] = 1'b0;
      exp_ovr[i] = 1'b0; exp_busy[i] = 1'b0;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  logic [AW-1:0] last_addr = '0;
  logic [7:0]    last_data = '0;

  always @(negedge clk) begin : compare
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    logic          e_we, e_fd, e_err, e_ovr, e_busy;
    if (reset || cyc >= MAXC) begin
      last_addr = '0; last_data = '0;
      e_we = 0; e_fd = 0; e_err = 0; e_ovr = 0; e_busy = 0;
    end else begin
      e_we = exp_we[cyc]; e_fd = exp_fd[cyc]; e_err = exp_err[cyc];
      e_ovr = exp_ovr[cyc]; e_busy = exp_busy[cyc];
      if (e_we) begin
        last_addr = exp_addr[cyc];
        last_data = exp_data[cyc];
      end
    end
    ea = last_addr;
    ed = last_data;
    total++;
    if ({wr_en, wr_addr, wr_data, frame_done, err, overrun, busy} !==
        {e_we, ea, ed, e_fd, e_err, e_ovr, e_busy}) begin
      bad++;
      $display("FAIL cycle %0d outputs: got we=%0b addr=%0d data=%02h fd=%0b err=%0b ovr=%0b busy=%0b, required we=%0b addr=%0d data=%02h fd=%0b err=%0b ovr=%0b busy=%0b",
               cyc, wr_en, wr_addr, wr_data, frame_done, err, overrun, busy,
               e_we, ea, ed, e_fd, e_err, e_ovr, e_busy);
    end
    if (!reset) begin
      if (wr_en) begin
        obs_addr.push_back(int'(wr_addr));
        obs_data.push_back(int'(wr_data));
        obs_edge.push_back(cyc);
      end
      if (err) err_e.push_back(cyc);
      if (frame_done) fd_e.push_back(cyc);
      if (overrun) ovr_e.push_back(cyc);
    end
  end

  task automatic step(input bit v, input logic [7:0] b);
    @(negedge clk);
    data_ready = v;
    data = v ? b : 8'($urandom);
    model_edge(cyc + 1, v, b);
    last_edge = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send_packet(input logic [7:0] r, input logic [7:0] ck, input int gmax);
    step(1'b1, SYNC);
    idle($urandom_range(0, gmax));
    step(1'b1, r);
    for (int i = 0; i < COLS; i++) begin
      idle($urandom_range(0, gmax));
      step(1'b1, pix[i]);
    end
    idle($urandom_range(0, gmax));
    step(1'b1, ck);
    chk_edge = last_edge;
  endtask

  function automatic logic [7:0] calc_chk(input logic [7:0] r);
    logic [7:0] x;
    x = r;
    for (int i = 0; i < COLS; i++) x ^= pix[i];
    return x;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    data_ready = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1 check("async_reset_outputs",
             int'({wr_en, wr_addr, wr_data, frame_done, err, overrun, busy}), 0);
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int kind;
    logic [7:0] r;
    logic [7:0] ck;

    repeat (3) @(negedge clk);
    check("reset_state", int'({wr_en, wr_addr, wr_data, frame_done, err, overrun, busy}), 0);
    #2 reset = 1'b0;
    idle(2);

    // Row 3, pixels 01..08, CHK 0B
    clear_logs();
    for (int i = 0; i < COLS; i++) pix[i] = 8'(i + 1);
    send_packet(8'h03, 8'h0B, 0);
    idle(COLS + 3);
    check("r3_nwrites", obs_addr.size(), 8);
    for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
      check("r3_addr", obs_addr[i], 24 + i);
      check("r3_data", obs_data[i], i + 1);
      check("r3_edge", obs_edge[i], chk_edge + i);
    end
    check("r3_err", err_e.size(), 0);
    check("r3_fd", fd_e.size(), 0);

    // Row 7, all-zero pixels, CHK 07 -> frame_done with address 63
    clear_logs();
    for (int i = 0; i < COLS; i++) pix[i] = 8'h00;
    send_packet(8'h07, 8'h07, 0);
    idle(COLS + 3);
    check("r7_nwrites", obs_addr.size(), 8);
    for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
      check("r7_addr", obs_addr[i], 56 + i);
      check("r7_data", obs_data[i], 0);
    end
    check("r7_fd_count", fd_e.size(), 1);
    if (fd_e.size() == 1 && obs_edge.size() == 8)
      check("r7_fd_with_last", fd_e[0], obs_edge[7]);

    // Bad checksum 0C, then a good packet for row 5
    clear_logs();
    for (int i = 0; i < COLS; i++) pix[i] = 8'(i + 1);
    send_packet(8'h03, 8'h0C, 0);
    idle(3);
    check("badchk_err_count", err_e.size(), 1);
    if (err_e.size() == 1) check("badchk_err_edge", err_e[0], chk_edge);
    check("badchk_nwrites", obs_addr.size(), 0);
    clear_logs();
    for (int i = 0; i < COLS; i++) pix[i] = 8'($urandom);
    send_packet(8'h05, calc_chk(8'h05), 0);
    idle(COLS + 3);
    check("after_bad_nwrites", obs_addr.size(), 8);
    if (obs_addr.size() > 0) check("after_bad_addr0", obs_addr[0], 40);

    // Row 9 out of range, junk 11, then a valid row 0 packet
    clear_logs();
    step(1'b1, SYNC);
    step(1'b1, 8'h09);
    idle(2);
    check("badrow_err_count", err_e.size(), 1);
    if (err_e.size() == 1) check("badrow_err_edge", err_e[0], last_edge - 2);
    check("badrow_busy", int'(busy), 0);
    step(1'b1, 8'h11);
    for (int i = 0; i < COLS; i++) pix[i] = 8'(8'h30 + i);
    send_packet(8'h00, calc_chk(8'h00), 0);
    idle(COLS + 3);
    check("row0_nwrites", obs_addr.size(), 8);
    if (obs_addr.size() == 8) begin
      check("row0_addr7", obs_addr[7], 7);
      check("row0_data7", obs_data[7], 8'h37);
    end

    // Byte injected two cycles into COMMIT
    clear_logs();
    for (int i = 0; i < COLS; i++) pix[i] = 8'(i + 1);
    send_packet(8'h04, calc_chk(8'h04), 0);
    step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    idle(COLS + 2);
    check("ovr_count", ovr_e.size(), 1);
    if (ovr_e.size() == 1) check("ovr_edge", ovr_e[0], chk_edge + 2);
    check("ovr_nwrites", obs_addr.size(), 8);
    for (int i = 0; i < obs_addr.size() && i < 8; i++) begin
      check("ovr_addr", obs_addr[i], 32 + i);
      check("ovr_data", obs_data[i], i + 1);
    end

    // Reset between pixel bytes 4 and 5, then a clean row 2 packet
    clear_logs();
    step(1'b1, SYNC);
    step(1'b1, 8'h02);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i + 1));
    do_reset();
    idle(2);
    for (int i = 0; i < COLS; i++) pix[i] = 8'($urandom);
    send_packet(8'h02, calc_chk(8'h02), 0);
    idle(COLS + 3);
    check("rst_nwrites", obs_addr.size(), 8);
    for (int i = 0; i < obs_addr.size() && i < 8; i++)
      check("rst_addr", obs_addr[i], 16 + i);

    // Randomized stream against the model
    for (int p = 0; p < 70 && cyc < MAXC - 200; p++) begin
      kind = $urandom_range(0, 9);
      r = 8'($urandom_range(0, ROWS - 1));
      for (int i = 0; i < COLS; i++)
        pix[i] = ($urandom_range(0, 7) == 0) ? SYNC : 8'($urandom);
      if (kind <= 5) begin
        send_packet(r, calc_chk(r), 2);
      end else if (kind == 6) begin
        ck = calc_chk(r) ^ (8'h01 << $urandom_range(0, 7));
        send_packet(r, ck, 1);
      end else if (kind == 7) begin
        step(1'b1, SYNC);
        step(1'b1, 8'($urandom_range(ROWS, 255)));
        repeat ($urandom_range(0, 3)) step(1'b1, 8'($urandom));
      end else begin
        repeat ($urandom_range(1, 4)) step(1'b1, 8'($urandom));
      end
      idle($urandom_range(0, COLS + 2));
    end
    idle(COLS + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
